// File: rtl/vending_machine_multi_if.sv
// rtl/vending_machine_multi_if.sv - Front-end/dispenser signal bundle for vending_machine_multi
// Ports: coin pulses, product select, cancel, restock and hopper ack toward the vendor;
//        vend pulse/id, credit, reject/error pulses, empty flags and change handshake back.
// master: front-end side (drives i_*), slave: vendor side (drives o_*).
interface vending_machine_multi_if #(
    parameter int N_PROD     = 4,
    parameter int MAX_CREDIT = 20
);
    localparam int SEL_W    = (N_PROD > 1) ? $clog2(N_PROD) : 1;
    localparam int CREDIT_W = $clog2(MAX_CREDIT + 1);

    logic                i_nickle;
    logic                i_dime;
    logic                i_quarter;
    logic                i_sel_valid;
    logic [SEL_W-1:0]    i_sel_id;
    logic                i_cancel;
    logic                i_restock;
    logic                i_change_ack;
    logic                o_soda;
    logic [SEL_W-1:0]    o_prod_id;
    logic [CREDIT_W-1:0] o_credit;
    logic                o_coin_reject;
    logic                o_sel_err;
    logic [N_PROD-1:0]   o_empty;
    logic                o_change_valid;
    logic [1:0]          o_change_type;
    logic                o_busy;

    modport master (
        output i_nickle, i_dime, i_quarter, i_sel_valid, i_sel_id,
               i_cancel, i_restock, i_change_ack,
        input  o_soda, o_prod_id, o_credit, o_coin_reject, o_sel_err,
               o_empty, o_change_valid, o_change_type, o_busy
    );

    modport slave (
        input  i_nickle, i_dime, i_quarter, i_sel_valid, i_sel_id,
               i_cancel, i_restock, i_change_ack,
        output o_soda, o_prod_id, o_credit, o_coin_reject, o_sel_err,
               o_empty, o_change_valid, o_change_type, o_busy
    );
endinterface

// File: rtl/vending_machine_multi.sv
// rtl/vending_machine_multi.sv - Multi-product vendor with per-product stock and coin-by-coin change
// Ports: clk (rising edge), rst (async, active high), bus (vending_machine_multi_if.slave):
//        coin/select/cancel/restock/ack inputs, vend/credit/reject/error/empty/change/busy outputs.
module vending_machine_multi #(
    parameter int N_PROD     = 4,
    parameter int PRICE      = 4,
    parameter int MAX_CREDIT = 20,
    parameter int STOCK_INIT = 8,
    parameter int STOCK_W    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    vending_machine_multi_if.slave  bus
);
    localparam int SEL_W    = (N_PROD > 1) ? $clog2(N_PROD) : 1;
    localparam int CREDIT_W = $clog2(MAX_CREDIT + 1);
    // Wide enough for credit plus a quarter even when the ceiling is tiny.
    localparam int SUM_W    = CREDIT_W + 3;

    typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

    state_t              state;
    logic [CREDIT_W-1:0] credit;
    logic [CREDIT_W-1:0] remaining;
    logic [STOCK_W-1:0]  stock     [N_PROD];
    logic [STOCK_W-1:0]  stock_nxt [N_PROD];
    logic [SEL_W-1:0]    prod_id;
    logic                soda;
    logic                coin_reject;
    logic                sel_err;
    logic [N_PROD-1:0]   empty;
    logic                change_valid;
    logic [1:0]          change_type;
    logic                busy;

    // Greedy change: largest coin not exceeding what is still owed.
    function automatic logic [CREDIT_W-1:0] chg_val(input logic [CREDIT_W-1:0] r);
        if (32'(r) >= 5)      return CREDIT_W'(5);
        else if (32'(r) >= 2) return CREDIT_W'(2);
        return CREDIT_W'(1);
    endfunction

    function automatic logic [1:0] chg_code(input logic [CREDIT_W-1:0] r);
        if (32'(r) >= 5)      return 2'b11;
        else if (32'(r) >= 2) return 2'b10;
        return 2'b01;
    endfunction

    // One coin per cycle, nickle beats dime beats quarter.
    logic [2:0]       coin_val;
    logic             coin_any;
    logic [SUM_W-1:0] coin_sum;
    logic             coin_fits;

    always_comb begin
        coin_val = 3'd0;
        if (bus.i_nickle)       coin_val = 3'd1;
        else if (bus.i_dime)    coin_val = 3'd2;
        else if (bus.i_quarter) coin_val = 3'd5;
    end

    assign coin_any  = (coin_val != 3'd0);
    assign coin_sum  = SUM_W'(credit) + SUM_W'(coin_val);
    assign coin_fits = (coin_sum <= SUM_W'(MAX_CREDIT));

    // An out-of-range id matches no product, so it reads as out of stock.
    logic sel_stocked;
    logic sel_ok;
    logic vend_take;

    always_comb begin
        sel_stocked = 1'b0;
        for (int p = 0; p < N_PROD; p++) begin
            if (bus.i_sel_id == SEL_W'(p) && stock[p] != '0) sel_stocked = 1'b1;
        end
    end

    assign sel_ok    = sel_stocked && (32'(credit) >= PRICE);
    assign vend_take = (state == S_CREDIT) && !bus.i_cancel && bus.i_sel_valid && sel_ok;

    // Restock overrides a same-cycle vend decrement.
    always_comb begin
        for (int p = 0; p < N_PROD; p++) begin
            stock_nxt[p] = stock[p];
            if (bus.i_restock)
                stock_nxt[p] = STOCK_W'(STOCK_INIT);
            else if (vend_take && bus.i_sel_id == SEL_W'(p))
                stock_nxt[p] = stock[p] - STOCK_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < N_PROD; p++) stock[p] <= STOCK_W'(STOCK_INIT);
            empty <= '0;
        end else begin
            for (int p = 0; p < N_PROD; p++) begin
                stock[p] <= stock_nxt[p];
                empty[p] <= (stock_nxt[p] == '0);
            end
        end
    end

    logic [CREDIT_W-1:0] rem_after;
    assign rem_after = remaining - chg_val(remaining);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            credit       <= '0;
            remaining    <= '0;
            prod_id      <= '0;
            soda         <= 1'b0;
            coin_reject  <= 1'b0;
            sel_err      <= 1'b0;
            change_valid <= 1'b0;
            change_type  <= 2'b00;
            busy         <= 1'b0;
        end else begin
            soda        <= 1'b0;
            coin_reject <= 1'b0;
            sel_err     <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Credit is zero here, so any select is short of the price.
                    sel_err <= bus.i_sel_valid;
                    if (coin_any) begin
                        if (coin_fits) begin
                            credit <= coin_sum[CREDIT_W-1:0];
                            state  <= S_CREDIT;
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                end
                S_CREDIT: begin
                    if (bus.i_cancel) begin
                        remaining    <= credit;
                        credit       <= '0;
                        change_valid <= 1'b1;
                        change_type  <= chg_code(credit);
                        busy         <= 1'b1;
                        coin_reject  <= coin_any;
                        state        <= S_CHANGE;
                    end else if (vend_take) begin
                        prod_id     <= bus.i_sel_id;
                        remaining   <= credit - CREDIT_W'(PRICE);
                        credit      <= '0;
                        soda        <= 1'b1;
                        busy        <= 1'b1;
                        coin_reject <= coin_any;
                        state       <= S_VEND;
                    end else begin
                        sel_err <= bus.i_sel_valid;
                        if (coin_any) begin
                            if (coin_fits) credit <= coin_sum[CREDIT_W-1:0];
                            else           coin_reject <= 1'b1;
                        end
                    end
                end
                S_VEND: begin
                    coin_reject <= coin_any;
                    if (remaining != '0) begin
                        change_valid <= 1'b1;
                        change_type  <= chg_code(remaining);
                        state        <= S_CHANGE;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_CHANGE: begin
                    coin_reject <= coin_any;
                    if (bus.i_change_ack) begin
                        remaining <= rem_after;
                        if (rem_after == '0) begin
                            change_valid <= 1'b0;
                            change_type  <= 2'b00;
                            busy         <= 1'b0;
                            state        <= S_IDLE;
                        end else begin
                            change_type <= chg_code(rem_after);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_soda         = soda;
    assign bus.o_prod_id      = prod_id;
    assign bus.o_credit       = credit;
    assign bus.o_coin_reject  = coin_reject;
    assign bus.o_sel_err      = sel_err;
    assign bus.o_empty        = empty;
    assign bus.o_change_valid = change_valid;
    assign bus.o_change_type  = change_type;
    assign bus.o_busy         = busy;
endmodule
